// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester IDs.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_memory between CPU and debug ports; req sampled in IDLE -> gnt two cycles later.
// One access per three cycles; a losing requester holds req (CPU sees cpu_stall) until its gnt pulse.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_last_winner;
   logic          r_id_q;
   logic          r_we_q;
   logic [AW-1:0] r_addr_q;
   logic [DW-1:0] r_wdata_q;
   logic [DW-1:0] r_rdata_q;
   logic          w_any_req;
   logic          w_pick;
   logic          w_resp;

   // On a conflict the port that did not win last time gets the memory.
   assign w_any_req = cpu_req | dbg_req;
   assign w_pick    = (cpu_req & dbg_req) ? ~r_last_winner : (cpu_req ? REQ_CPU : REQ_DBG);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_last_winner <= REQ_DBG;
         r_id_q        <= REQ_CPU;
         r_we_q        <= 1'b0;
         r_addr_q      <= '0;
         r_wdata_q     <= '0;
         r_rdata_q     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_any_req) begin
            r_id_q        <= w_pick;
            r_last_winner <= w_pick;
            r_we_q        <= (w_pick == REQ_DBG) ? dbg_we    : cpu_we;
            r_addr_q      <= (w_pick == REQ_DBG) ? dbg_addr  : cpu_addr;
            r_wdata_q     <= (w_pick == REQ_DBG) ? dbg_wdata : cpu_wdata;
         end
         if (r_state == ACCESS && !r_we_q) begin
            r_rdata_q <= mem_rdata;
         end
      end
   end

   // Gating with rst_n keeps a reset landing in ACCESS/RESP from writing or granting.
   assign w_resp = (r_state == RESP) & rst_n;

   always_comb begin
      w_state_nxt = r_state;
      mem_addr    = r_addr_q;
      mem_wdata   = r_wdata_q;
      mem_we      = 1'b0;
      cpu_gnt     = 1'b0;
      dbg_gnt     = 1'b0;
      cpu_rvalid  = 1'b0;
      dbg_rvalid  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) w_state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_we      = r_we_q & rst_n;
            w_state_nxt = RESP;
         end
         RESP: begin
            cpu_gnt     = w_resp & (r_id_q == REQ_CPU);
            dbg_gnt     = w_resp & (r_id_q == REQ_DBG);
            cpu_rvalid  = cpu_gnt & ~r_we_q;
            dbg_rvalid  = dbg_gnt & ~r_we_q;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign cpu_rdata = r_rdata_q;
   assign dbg_rdata = r_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a word-array memory and reference memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // data_memory stand-in: 64 words, combinational read, clocked write
   logic [31:0] dmem [0:63];
   assign mem_rdata = dmem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        cpu_q[$];
   acc_t        dbg_q[$];
   logic [31:0] ref_mem [0:63];
   int          checks = 0;
   int          failures = 0;
   int          cyc_cnt = 0;
   bit          log_en = 1'b0;
   int          log_port[$];
   int          log_cyc[$];
   bit          mw_pend = 1'b0;
   logic [31:0] mw_addr, mw_data;

   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: accesses complete in grant order against a flat memory array.
   task automatic serve(input bit port, input logic rvalid, input logic [31:0] rdata);
      acc_t e;
      if ((port ? dbg_q.size() : cpu_q.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_gnt: port %0d granted with no request outstanding", port);
      end else begin
         e = port ? dbg_q.pop_front() : cpu_q.pop_front();
         chk(port ? "dbg_rvalid" : "cpu_rvalid", 32'(rvalid), 32'(!e.we));
         if (!e.we) begin
            chk(port ? "dbg_rdata" : "cpu_rdata", rdata, ref_mem[e.addr[7:2]]);
         end else begin
            chk("write_strobe_seen", 32'(mw_pend), 32'd1);
            chk("write_mem_addr", mw_addr, e.addr);
            chk("write_mem_wdata", mw_data, e.wdata);
            mw_pend = 1'b0;
            ref_mem[e.addr[7:2]] = e.wdata;
         end
         if (log_en) begin
            log_port.push_back(int'(port));
            log_cyc.push_back(cyc_cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mw_pend = 1'b0;
      end else begin
         chk("single_gnt", 32'(cpu_gnt & dbg_gnt), 32'd0);
         chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_gnt));
         if (!cpu_gnt) chk("cpu_rvalid_quiet", 32'(cpu_rvalid), 32'd0);
         if (!dbg_gnt) chk("dbg_rvalid_quiet", 32'(dbg_rvalid), 32'd0);
         if (cpu_gnt) serve(1'b0, cpu_rvalid, cpu_rdata);
         if (dbg_gnt) serve(1'b1, dbg_rvalid, dbg_rdata);
         chk("write_strobe_stray", 32'(mw_pend), 32'd0);
         mw_pend = 1'b0;
         if (mem_we) begin
            mw_pend = 1'b1;
            mw_addr = mem_addr;
            mw_data = mem_wdata;
         end
      end
   end

   // Called just after a rising edge; returns edges until gnt and the read data seen with it.
   task automatic access(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
      acc_t e;
      bit   got;
      e.we = we; e.addr = addr; e.wdata = wd;
      if (port) begin
         dbg_q.push_back(e);
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
      end else begin
         cpu_q.push_back(e);
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
         #1;
         chk("cpu_stall_on_req", 32'(cpu_stall), 32'd1);
      end
      lat = 0;
      got = 1'b0;
      while (lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (port ? dbg_gnt : cpu_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL gnt_timeout: port %0d got no gnt within %0d cycles", port, lat);
      end
      chk("latency_bound", 32'(lat <= 5), 32'd1);
      rd = port ? dbg_rdata : cpu_rdata;
      @(posedge clk); #1;
      if (port) dbg_req = 1'b0; else cpu_req = 1'b0;
   endtask

   task automatic rand_drv(input bit port, input int n);
      int          lat;
      logic [31:0] rd, addr, wd;
      logic        we;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         we   = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 15)) << 2;
         wd   = $urandom;
         access(port, we, addr, wd, lat, rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat_c, lat_d;
      logic [31:0] rd_c, rd_d, old_word;

      for (int i = 0; i < 64; i++) begin
         dmem[i]    = {16'hA5C3, 16'(i)};
         ref_mem[i] = {16'hA5C3, 16'(i)};
      end
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'h1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'h2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);

      // first conflict after reset: CPU wins, DBG follows one slot later
      rst_n = 1'b1;
      fork
         access(1'b0, 1'b1, 32'h08, 32'h1111_2222, lat_c, rd_c);
         access(1'b1, 1'b0, 32'h08, 32'h0, lat_d, rd_d);
      join
      chk("first_conflict_cpu_lat", 32'(lat_c), 32'd2);
      chk("first_conflict_dbg_lat", 32'(lat_d), 32'd5);
      chk("first_conflict_dbg_rdata", rd_d, 32'h1111_2222);

      access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat_c, rd_c);
      chk("cpu_write_lat", 32'(lat_c), 32'd2);
      access(1'b1, 1'b0, 32'h10, 32'h0, lat_d, rd_d);
      chk("dbg_read_lat", 32'(lat_d), 32'd2);
      chk("dbg_read_rdata", rd_d, 32'hDEAD_BEEF);

      // both ports saturating: strict alternation starting with CPU, 3 cycles apart
      log_en = 1'b1;
      fork
         begin
            int l; logic [31:0] r;
            for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 32'h40 + 32'(i) * 4, $urandom, l, r);
         end
         begin
            int l; logic [31:0] r;
            for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 32'h40 + 32'(i) * 4, 32'h0, l, r);
         end
      join
      log_en = 1'b0;
      chk("alt_count", 32'(log_port.size()), 32'd8);
      for (int i = 0; i < log_port.size(); i++) begin
         chk("alt_order", 32'(log_port[i]), 32'(i % 2));
         if (i > 0) chk("alt_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
      end

      // reset landing in ACCESS of a DBG write must not touch memory or grant
      old_word = dmem[8];
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dbg_req = 1'b0;
      chk("abort_no_gnt", 32'(dbg_gnt), 32'd0);
      chk("abort_mem_kept", dmem[8], old_word);
      access(1'b1, 1'b0, 32'h20, 32'h0, lat_d, rd_d);
      chk("abort_idle_lat", 32'(lat_d), 32'd2);
      chk("abort_read_back", rd_d, old_word);

      // address change during ACCESS is ignored
      begin
         acc_t e;
         e.we = 1'b0; e.addr = 32'h30; e.wdata = 32'h0;
         dbg_q.push_back(e);
      end
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30; dbg_wdata = 32'h0;
      @(posedge clk); #1;
      dbg_addr = 32'h34;
      #1;
      chk("stable_mem_addr", mem_addr, 32'h30);
      @(posedge clk); #1;
      chk("stable_rvalid", 32'(dbg_rvalid), 32'd1);
      chk("stable_rdata", dbg_rdata, ref_mem[12]);
      @(posedge clk); #1;
      dbg_req = 1'b0;

      fork
         rand_drv(1'b0, 40);
         rand_drv(1'b1, 40);
      join

      repeat (5) @(posedge clk);
      #1;
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
